// File: rtl/pll_supervisor_if.sv
// PLL supervisor signal bundle: lock/soft-reset requests in, PLL and system reset controls out.
interface pll_supervisor_if;
  logic       lock;
  logic       soft_reset_req;
  logic       pll_reset;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [7:0] lost_lock_cnt;
  logic [2:0] state_o;

  modport master (
    output lock, soft_reset_req,
    input  pll_reset, sys_rst, ready, fault, lost_lock_cnt, state_o
  );

  modport slave (
    input  lock, soft_reset_req,
    output pll_reset, sys_rst, ready, fault, lost_lock_cnt, state_o
  );
endinterface

// File: rtl/pll_supervisor.sv
// Reference-clock-domain PLL supervisor: pulses the PLL reset, waits for a stable lock,
// sequences the system reset and latches a fault after repeated lock timeouts.
module pll_supervisor #(
  parameter int unsigned LOCK_SYNC_STAGES = 2,
  parameter int unsigned PLL_RST_CYCLES   = 27,
  parameter int unsigned LOCK_TIMEOUT     = 27000,
  parameter int unsigned STABLE_CYCLES    = 2700,
  parameter int unsigned MAX_RETRIES      = 3,
  parameter int unsigned CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  pll_supervisor_if.slave  bus
);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_PLLRST    = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            timer_q, timer_d;
  logic [RETRY_W-1:0]          retry_q, retry_d;
  logic [7:0]                  lost_q, lost_d;
  logic [LOCK_SYNC_STAGES-1:0] sync_q, sync_d;
  logic                        pll_reset_q, pll_reset_d;
  logic                        sys_rst_q, sys_rst_d;
  logic                        ready_q, ready_d;
  logic                        fault_q, fault_d;
  logic                        lock_s;

  // Lock synchronizer; every decision below looks only at lock_s.
  assign sync_d = {sync_q[LOCK_SYNC_STAGES-2:0], bus.lock};
  assign lock_s = sync_q[LOCK_SYNC_STAGES-1];

  // State register plus registered outputs; reset forces the PLL and system into reset at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PLLRST;
      timer_q     <= '0;
      retry_q     <= '0;
      lost_q      <= '0;
      sync_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      sync_q      <= sync_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state, timer and counters; soft reset overrides every other transition.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    lost_d  = lost_q;

    if (state_q == S_RUN && !lock_s && lost_q != 8'hFF) begin
      lost_d = lost_q + 8'd1;
    end

    if (bus.soft_reset_req) begin
      state_d = S_PLLRST;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_PLLRST: begin
          if (timer_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_STABLE;
            timer_d = '0;
          end else if (timer_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            timer_d = '0;
            retry_d = retry_q + RETRY_W'(1);
            state_d = (retry_q == RETRY_W'(MAX_RETRIES - 1)) ? S_FAULT : S_PLLRST;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == CNT_W'(STABLE_CYCLES - 1)) begin
            state_d = S_RUN;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          retry_d = '0;
          if (!lock_s) begin
            state_d = S_PLLRST;
            timer_d = '0;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_PLLRST;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies track state_q exactly.
  always_comb begin
    pll_reset_d = 1'b0;
    sys_rst_d   = 1'b1;
    ready_d     = 1'b0;
    fault_d     = 1'b0;
    case (state_d)
      S_PLLRST: pll_reset_d = 1'b1;
      S_RUN: begin
        sys_rst_d = 1'b0;
        ready_d   = 1'b1;
      end
      S_FAULT:  fault_d = 1'b1;
      default:  ;
    endcase
  end

  assign bus.pll_reset     = pll_reset_q;
  assign bus.sys_rst       = sys_rst_q;
  assign bus.ready         = ready_q;
  assign bus.fault         = fault_q;
  assign bus.lost_lock_cnt = lost_q;
  assign bus.state_o       = 3'(state_q);
endmodule
